dmem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-ported data memory. It shares the dmem port between the processor (port 0) and a secondary master (port 1, e.g. loader or debug engine). It registers the winning command, drives address_dmem, data and wren, waits out the memory read latency, and returns read data to the owning requester. It sits between both masters and the dmem instance at the top level.

---
 rtl/dmem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-ported data memory.
// Registers the winning command, drives the dmem port, waits out RD_LAT and returns read data to the owner.
module dmem_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t              r_state;
    logic                r_last;
    logic                r_owner;
    logic                r_we;
    logic [1:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_wren;
    logic                r_rv0;
    logic                r_rv1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic w_idle;
    logic w_sel0;
    logic w_sel1;
    logic w_gnt0;
    logic w_gnt1;

    // r_last=1 means port 1 won most recently, so port 0 wins a tie.
    assign w_idle = (r_state == IDLE);
    assign w_sel0 = p0_req & (~p1_req | r_last);
    assign w_sel1 = p1_req & (~p0_req | ~r_last);
    assign w_gnt0 = reset & w_idle & w_sel0;
    assign w_gnt1 = reset & w_idle & w_sel1;

    assign p0_gnt       = w_gnt0;
    assign p1_gnt       = w_gnt1;
    assign p0_rvalid    = r_rv0;
    assign p1_rvalid    = r_rv1;
    assign p0_rdata     = r_rdata0;
    assign p1_rdata     = r_rdata1;
    assign address_dmem = r_addr;
    assign data         = r_data;
    assign wren         = r_wren;
    assign busy         = ~w_idle;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_wren   <= 1'b0;
            r_rv0    <= 1'b0;
            r_rv1    <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_wren <= 1'b0;
            r_rv0  <= 1'b0;
            r_rv1  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_owner <= w_gnt1;
                        r_last  <= w_gnt1;
                        r_we    <= w_gnt1 ? p1_we    : p0_we;
                        r_addr  <= w_gnt1 ? p1_addr  : p0_addr;
                        r_data  <= w_gnt1 ? p1_wdata : p0_wdata;
                        // wren is registered so it is high exactly during ISSUE
                        r_wren  <= w_gnt1 ? p1_we    : p0_we;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= LAT;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 2'd1) begin
                        if (r_owner) begin
                            r_rdata1 <= q_dmem;
                            r_rv1    <= 1'b1;
                        end else begin
                            r_rdata0 <= q_dmem;
                            r_rv0    <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: one RD_LAT=1 instance driven by a vector table,
// one RD_LAT=3 instance for the latency sweep, each with a small memory model.
module tb_dmem_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // RD_LAT=1 instance
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [11:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, wren, busy;
    logic [31:0] p0_rdata, p1_rdata, data, q_dmem;
    logic [11:0] address_dmem;

    // RD_LAT=3 instance
    logic        x0_req, x0_we, x1_req, x1_we;
    logic [11:0] x0_addr, x1_addr;
    logic [31:0] x0_wdata, x1_wdata;
    logic        x0_gnt, x1_gnt, x0_rvalid, x1_rvalid, x_wren, x_busy;
    logic [31:0] x0_rdata, x1_rdata, x_data, x_q;
    logic [11:0] x_addr;

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem), .busy(busy)
    );

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clock(clock), .reset(reset),
        .p0_req(x0_req), .p0_we(x0_we), .p0_addr(x0_addr), .p0_wdata(x0_wdata),
        .p0_gnt(x0_gnt), .p0_rvalid(x0_rvalid), .p0_rdata(x0_rdata),
        .p1_req(x1_req), .p1_we(x1_we), .p1_addr(x1_addr), .p1_wdata(x1_wdata),
        .p1_gnt(x1_gnt), .p1_rvalid(x1_rvalid), .p1_rdata(x1_rdata),
        .address_dmem(x_addr), .data(x_data), .wren(x_wren),
        .q_dmem(x_q), .busy(x_busy)
    );

    // Memory models: 1-cycle synchronous read, and a 3-stage read pipe.
    logic [31:0] mem1 [4096];
    logic [31:0] mem3 [4096];
    logic [31:0] s1, s2, s3;
    always @(posedge clock) begin
        if (wren) mem1[address_dmem] <= data;
        q_dmem <= mem1[address_dmem];
        if (x_wren) mem3[x_addr] <= x_data;
        s1 <= mem3[x_addr];
        s2 <= s1;
        s3 <= s2;
    end
    assign x_q = s3;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        r0, w0; logic [11:0] a0; logic [31:0] d0;
        logic        r1, w1; logic [11:0] a1; logic [31:0] d1;
        logic        g0, g1, wr; logic [11:0] ad; logic [31:0] dt;
        logic        v0, v1; logic [31:0] rd0, rd1; logic bz;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, w0, input logic [11:0] a0, input logic [31:0] d0,
        input logic r1, w1, input logic [11:0] a1, input logic [31:0] d1,
        input logic g0, g1, wr, input logic [11:0] ad, input logic [31:0] dt,
        input logic v0, v1, input logic [31:0] rd0, rd1, input logic bz);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.wr = wr; v.ad = ad; v.dt = dt;
        v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1; v.bz = bz;
        return v;
    endfunction

    task automatic clr_inputs();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        x0_req = 0; x0_we = 0; x0_addr = '0; x0_wdata = '0;
        x1_req = 0; x1_we = 0; x1_addr = '0; x1_wdata = '0;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] K1 = 32'h11111111;
    localparam logic [31:0] K2 = 32'h22222222;

    vec_t vt[24];

    initial begin
        //        r0 w0 a0     d0   r1 w1 a1     d1   g0 g1 wr ad     dt   v0 v1 rd0 rd1 bz
        vt[0]  = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 0, 12'h000, 0,  0, 0, 0,  0,  0);
        vt[1]  = mk(1, 1, 12'h010, DB, 0, 0, 12'h000, 0,  1, 0, 0, 12'h000, 0,  0, 0, 0,  0,  0);
        vt[2]  = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 1, 12'h010, DB, 0, 0, 0,  0,  1);
        vt[3]  = mk(0, 0, 12'h000, 0,  1, 0, 12'h010, 0,  0, 1, 0, 12'h010, DB, 0, 0, 0,  0,  0);
        vt[4]  = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 0, 12'h010, 0,  0, 0, 0,  0,  1);
        vt[5]  = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 0, 12'h010, 0,  0, 0, 0,  0,  1);
        vt[6]  = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 0, 12'h010, 0,  0, 1, 0,  DB, 0);
        vt[7]  = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 0, 12'h010, 0,  0, 0, 0,  DB, 0);
        vt[8]  = mk(1, 1, 12'h020, K1, 1, 1, 12'h030, K2, 1, 0, 0, 12'h010, 0,  0, 0, 0,  DB, 0);
        vt[9]  = mk(1, 1, 12'h020, K1, 1, 1, 12'h030, K2, 0, 0, 1, 12'h020, K1, 0, 0, 0,  DB, 1);
        vt[10] = mk(1, 1, 12'h020, K1, 1, 1, 12'h030, K2, 0, 1, 0, 12'h020, K1, 0, 0, 0,  DB, 0);
        vt[11] = mk(1, 1, 12'h020, K1, 1, 1, 12'h030, K2, 0, 0, 1, 12'h030, K2, 0, 0, 0,  DB, 1);
        vt[12] = mk(1, 1, 12'h020, K1, 1, 1, 12'h030, K2, 1, 0, 0, 12'h030, K2, 0, 0, 0,  DB, 0);
        vt[13] = mk(1, 1, 12'h020, K1, 1, 1, 12'h030, K2, 0, 0, 1, 12'h020, K1, 0, 0, 0,  DB, 1);
        vt[14] = mk(1, 1, 12'h020, K1, 1, 1, 12'h030, K2, 0, 1, 0, 12'h020, K1, 0, 0, 0,  DB, 0);
        vt[15] = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 1, 12'h030, K2, 0, 0, 0,  DB, 1);
        vt[16] = mk(1, 0, 12'h030, 0,  0, 0, 12'h000, 0,  1, 0, 0, 12'h030, K2, 0, 0, 0,  DB, 0);
        vt[17] = mk(0, 0, 12'h000, 0,  1, 0, 12'h020, 0,  0, 0, 0, 12'h030, 0,  0, 0, 0,  DB, 1);
        vt[18] = mk(0, 0, 12'h000, 0,  1, 0, 12'h020, 0,  0, 0, 0, 12'h030, 0,  0, 0, 0,  DB, 1);
        vt[19] = mk(0, 0, 12'h000, 0,  1, 0, 12'h020, 0,  0, 1, 0, 12'h030, 0,  1, 0, K2, DB, 0);
        vt[20] = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 0, 12'h020, 0,  0, 0, K2, DB, 1);
        vt[21] = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 0, 12'h020, 0,  0, 0, K2, DB, 1);
        vt[22] = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 0, 12'h020, 0,  0, 1, K2, K1, 0);
        vt[23] = mk(0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  0, 0, 0, 12'h020, 0,  0, 0, K2, K1, 0);

        clr_inputs();

        // Reset held low with random inputs: every output stays zero.
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            p0_req = 1'($urandom); p0_we = 1'($urandom); p0_addr = 12'($urandom); p0_wdata = $urandom;
            p1_req = 1'($urandom); p1_we = 1'($urandom); p1_addr = 12'($urandom); p1_wdata = $urandom;
            x0_req = 1'($urandom); x1_req = 1'($urandom);
            if (i == 2) begin
                p0_req = 1; p1_req = 1; x0_req = 1; x1_req = 1;
            end
            @(negedge clock);
            chk($sformatf("rst%0d gnt0", i), 32'(p0_gnt), 0);
            chk($sformatf("rst%0d gnt1", i), 32'(p1_gnt), 0);
            chk($sformatf("rst%0d wren", i), 32'(wren), 0);
            chk($sformatf("rst%0d addr", i), 32'(address_dmem), 0);
            chk($sformatf("rst%0d data", i), data, 0);
            chk($sformatf("rst%0d rv", i), {30'd0, p1_rvalid, p0_rvalid}, 0);
            chk($sformatf("rst%0d rdata0", i), p0_rdata, 0);
            chk($sformatf("rst%0d rdata1", i), p1_rdata, 0);
            chk($sformatf("rst%0d busy", i), 32'(busy), 0);
            chk($sformatf("rst%0d x_gnt", i), {30'd0, x1_gnt, x0_gnt}, 0);
        end
        @(posedge clock); #1;
        clr_inputs();
        reset = 1'b1;

        // Table-driven vectors on the RD_LAT=1 instance.
        for (int i = 0; i < 24; i++) begin
            @(posedge clock); #1;
            p0_req = vt[i].r0; p0_we = vt[i].w0; p0_addr = vt[i].a0; p0_wdata = vt[i].d0;
            p1_req = vt[i].r1; p1_we = vt[i].w1; p1_addr = vt[i].a1; p1_wdata = vt[i].d1;
            @(negedge clock);
            chk($sformatf("v%0d gnt0", i), 32'(p0_gnt), 32'(vt[i].g0));
            chk($sformatf("v%0d gnt1", i), 32'(p1_gnt), 32'(vt[i].g1));
            chk($sformatf("v%0d wren", i), 32'(wren), 32'(vt[i].wr));
            chk($sformatf("v%0d addr", i), 32'(address_dmem), 32'(vt[i].ad));
            chk($sformatf("v%0d data", i), data, vt[i].dt);
            chk($sformatf("v%0d rvalid0", i), 32'(p0_rvalid), 32'(vt[i].v0));
            chk($sformatf("v%0d rvalid1", i), 32'(p1_rvalid), 32'(vt[i].v1));
            chk($sformatf("v%0d rdata0", i), p0_rdata, vt[i].rd0);
            chk($sformatf("v%0d rdata1", i), p1_rdata, vt[i].rd1);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].bz));
        end

        // Reset during WAIT: read dropped, pointer restored to favour port 0.
        @(posedge clock); #1;
        p0_req = 1; p0_we = 0; p0_addr = 12'h010; p0_wdata = '0;
        @(negedge clock);
        chk("mid gnt0", 32'(p0_gnt), 1);
        @(posedge clock); #1;
        p0_req = 0;
        @(negedge clock);
        chk("mid issue busy", 32'(busy), 1);
        @(posedge clock); #3;
        chk("mid wait busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("mid rst busy", 32'(busy), 0);
        chk("mid rst wren", 32'(wren), 0);
        chk("mid rst rdata0", p0_rdata, 0);
        chk("mid rst addr", 32'(address_dmem), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("mid post%0d rvalid0", i), 32'(p0_rvalid), 0);
            chk($sformatf("mid post%0d busy", i), 32'(busy), 0);
            @(posedge clock); #1;
        end
        p0_req = 1; p0_we = 0; p0_addr = 12'h010;
        p1_req = 1; p1_we = 0; p1_addr = 12'h020;
        @(negedge clock);
        chk("mid both gnt0", 32'(p0_gnt), 1);
        chk("mid both gnt1", 32'(p1_gnt), 0);
        @(posedge clock); #1;
        clr_inputs();
        repeat (4) @(posedge clock);
        #1;

        // RD_LAT=3 latency sweep: two writes, then a port 1 read of 0x0FF.
        x0_req = 1; x0_we = 1; x0_addr = 12'h0FF; x0_wdata = 32'h12345678;
        @(negedge clock);
        chk("lat w1 gnt0", 32'(x0_gnt), 1);
        @(posedge clock); #1;
        x0_req = 0;
        @(negedge clock);
        chk("lat w1 wren", 32'(x_wren), 1);
        @(posedge clock); #1;
        x0_req = 1; x0_we = 1; x0_addr = 12'h0AA; x0_wdata = 32'hCAFEF00D;
        @(negedge clock);
        chk("lat w2 gnt0", 32'(x0_gnt), 1);
        @(posedge clock); #1;
        x0_req = 0;
        @(posedge clock); #1;
        x1_req = 1; x1_we = 0; x1_addr = 12'h0FF; x1_wdata = '0;
        @(negedge clock);
        chk("lat c0 gnt1", 32'(x1_gnt), 1);
        @(posedge clock); #1;
        x1_req = 0;
        @(negedge clock);
        chk("lat c1 busy", 32'(x_busy), 1);
        chk("lat c1 addr", 32'(x_addr), 32'h0FF);
        for (int c = 2; c <= 4; c++) begin
            @(posedge clock); #1;
            x0_req = 1; x0_we = 0; x0_addr = 12'h0AA; x0_wdata = '0;
            @(negedge clock);
            chk($sformatf("lat c%0d gnt0", c), 32'(x0_gnt), 0);
            chk($sformatf("lat c%0d rvalid1", c), 32'(x1_rvalid), 0);
            chk($sformatf("lat c%0d busy", c), 32'(x_busy), 1);
        end
        @(posedge clock); #1;
        @(negedge clock);
        chk("lat c5 rvalid1", 32'(x1_rvalid), 1);
        chk("lat c5 rdata1", x1_rdata, 32'h12345678);
        chk("lat c5 rvalid0", 32'(x0_rvalid), 0);
        chk("lat c5 gnt0", 32'(x0_gnt), 1);
        @(posedge clock); #1;
        x0_req = 0;
        @(negedge clock);
        chk("lat c6 rvalid1", 32'(x1_rvalid), 0);
        chk("lat c6 rdata1 hold", x1_rdata, 32'h12345678);
        repeat (6) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
